// File: rtl/control_sequencer.sv
// ============================================================================
// Module   : control_sequencer
// Brief    : Multi-cycle Moore control FSM for the Mini SRC datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer #(
  parameter logic [4:0] ADD_OP = 5'd3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        mem_ack,
  input  logic        stop,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Zin,
  output logic        Zlowout,
  output logic        PCin,
  output logic        Read,
  output logic        Write,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Cout,
  output logic        CONin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        RIn,
  output logic        ROut,
  output logic        BAOut,
  output logic [4:0]  alu_op,
  output logic        run
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  state_t state, state_next;

  logic [4:0] opcode;
  logic       is_r, is_i, is_ldi, is_ld, is_st, is_br, is_jal, is_jr, is_halt;
  logic       has_exec;
  state_t     boundary;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];

  assign is_ld    = (opcode == 5'd0);
  assign is_ldi   = (opcode == 5'd1);
  assign is_st    = (opcode == 5'd2);
  assign is_r     = (opcode >= 5'd3) && (opcode <= 5'd11);
  assign is_i     = (opcode >= 5'd12) && (opcode <= 5'd14);
  assign is_br    = (opcode == 5'd19);
  assign is_jal   = (opcode == 5'd20);
  assign is_jr    = (opcode == 5'd21);
  assign is_halt  = (opcode == 5'd27);
  assign has_exec = is_ld | is_ldi | is_st | is_r | is_i | is_br | is_jal | is_jr;

  // stop only matters on the edge that leaves an instruction's last state
  assign boundary = stop ? S_HALT : S_T0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_RST;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RST:  state_next = S_T0;
      S_T0:   state_next = S_T1;
      S_T1:   state_next = mem_ack ? S_T2 : S_T1;
      S_T2: begin
        if (is_halt)       state_next = S_HALT;
        else if (has_exec) state_next = S_T3;
        else               state_next = boundary;
      end
      S_T3:   state_next = (is_jr || !has_exec) ? boundary : S_T4;
      S_T4:   state_next = (is_jal || !has_exec) ? boundary : S_T5;
      S_T5:   state_next = (is_ld || is_st || is_br) ? S_T6 : boundary;
      S_T6: begin
        if (is_ld)      state_next = mem_ack ? S_T7 : S_T6;
        else if (is_st) state_next = S_T7;
        else            state_next = boundary;
      end
      S_T7: begin
        if (is_st) state_next = mem_ack ? boundary : S_T7;
        else       state_next = boundary;
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_RST;
    endcase
  end

  always_comb begin
    PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; Zin = 1'b0; Zlowout = 1'b0;
    PCin = 1'b0; Read = 1'b0; Write = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
    IRin = 1'b0; Yin = 1'b0; Cout = 1'b0; CONin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; RIn = 1'b0; ROut = 1'b0; BAOut = 1'b0;
    alu_op = 5'd0;
    run    = 1'b0;
    if (state != S_RST && state != S_HALT) begin
      run    = 1'b1;
      alu_op = ADD_OP;
    end
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (is_r || is_i) begin
          Grb = 1'b1; ROut = 1'b1; Yin = 1'b1;
        end else if (is_ldi || is_ld || is_st) begin
          Grb = 1'b1; BAOut = 1'b1; Yin = 1'b1;
        end else if (is_br) begin
          Gra = 1'b1; ROut = 1'b1; CONin = 1'b1;
        end else if (is_jal) begin
          PCout = 1'b1; Grb = 1'b1; RIn = 1'b1;
        end else if (is_jr) begin
          Gra = 1'b1; ROut = 1'b1; PCin = 1'b1;
        end
      end
      S_T4: begin
        if (is_r) begin
          Grc = 1'b1; ROut = 1'b1; Zin = 1'b1; alu_op = opcode;
        end else if (is_i) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = opcode;
        end else if (is_ldi || is_ld || is_st) begin
          Cout = 1'b1; Zin = 1'b1;
        end else if (is_br) begin
          PCout = 1'b1; Yin = 1'b1;
        end else if (is_jal) begin
          Gra = 1'b1; ROut = 1'b1; PCin = 1'b1;
        end
      end
      S_T5: begin
        if (is_r || is_i || is_ldi) begin
          Zlowout = 1'b1; Gra = 1'b1; RIn = 1'b1;
        end else if (is_ld || is_st) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else if (is_br) begin
          Cout = 1'b1; Zin = 1'b1;
        end
      end
      S_T6: begin
        if (is_ld) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (is_st) begin
          Gra = 1'b1; ROut = 1'b1; MDRin = 1'b1;
        end else if (is_br) begin
          Zlowout = 1'b1; PCin = CON_FF;
        end
      end
      S_T7: begin
        if (is_ld) begin
          MDRout = 1'b1; Gra = 1'b1; RIn = 1'b1;
        end else if (is_st) begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module   : tb_control_sequencer
// Brief    : Self-checking bench: per-instruction microstep table model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

  localparam logic [19:0] M_PCOUT  = 20'h80000, M_MARIN = 20'h40000, M_INCPC = 20'h20000,
                          M_ZIN    = 20'h10000, M_ZLOW  = 20'h08000, M_PCIN  = 20'h04000,
                          M_READ   = 20'h02000, M_WRITE = 20'h01000, M_MDRIN = 20'h00800,
                          M_MDROUT = 20'h00400, M_IRIN  = 20'h00200, M_YIN   = 20'h00100,
                          M_COUT   = 20'h00080, M_CONIN = 20'h00040, M_GRA   = 20'h00020,
                          M_GRB    = 20'h00010, M_GRC   = 20'h00008, M_RIN   = 20'h00004,
                          M_ROUT   = 20'h00002, M_BAOUT = 20'h00001;
  localparam logic [4:0]  ADD = 5'd3;

  logic clock = 1'b0, reset = 1'b1;
  logic [31:0] IR = 32'h0;
  logic CON_FF = 1'b0, mem_ack = 1'b1, stop = 1'b0;
  logic PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write, MDRin, MDRout;
  logic IRin, Yin, Cout, CONin, Gra, Grb, Grc, RIn, ROut, BAOut, run;
  logic [4:0] alu_op;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [19:0] mask;
    logic [4:0]  alu;
    bit          wt;
  } step_t;
  step_t seq[$];

  control_sequencer #(.ADD_OP(ADD)) dut (
    .clock(clock), .reset(reset), .IR(IR), .CON_FF(CON_FF), .mem_ack(mem_ack), .stop(stop),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout), .PCin(PCin),
    .Read(Read), .Write(Write), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .Cout(Cout), .CONin(CONin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .RIn(RIn), .ROut(ROut),
    .BAOut(BAOut), .alu_op(alu_op), .run(run)
  );

  always #5 clock = ~clock;

  function automatic logic [25:0] observe();
    return {PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write, MDRin, MDRout,
            IRin, Yin, Cout, CONin, Gra, Grb, Grc, RIn, ROut, BAOut, alu_op, run};
  endfunction

  function automatic void push(input logic [19:0] m, input logic [4:0] a, input bit w);
    step_t s;
    s.mask = m; s.alu = a; s.wt = w;
    seq.push_back(s);
  endfunction

  // Expected microstep list of one instruction, fetch included
  function automatic void build_seq(input logic [4:0] op, input logic con);
    seq.delete();
    push(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, ADD, 1'b0);
    push(M_ZLOW | M_PCIN | M_READ | M_MDRIN, ADD, 1'b1);
    push(M_MDROUT | M_IRIN, ADD, 1'b0);
    if (op >= 3 && op <= 14) begin
      push(M_GRB | M_ROUT | M_YIN, ADD, 1'b0);
      if (op <= 11) push(M_GRC | M_ROUT | M_ZIN, op, 1'b0);
      else          push(M_COUT | M_ZIN, op, 1'b0);
      push(M_ZLOW | M_GRA | M_RIN, ADD, 1'b0);
    end else if (op <= 2) begin
      push(M_GRB | M_BAOUT | M_YIN, ADD, 1'b0);
      push(M_COUT | M_ZIN, ADD, 1'b0);
      if (op == 1) push(M_ZLOW | M_GRA | M_RIN, ADD, 1'b0);
      else begin
        push(M_ZLOW | M_MARIN, ADD, 1'b0);
        if (op == 0) begin
          push(M_READ | M_MDRIN, ADD, 1'b1);
          push(M_MDROUT | M_GRA | M_RIN, ADD, 1'b0);
        end else begin
          push(M_GRA | M_ROUT | M_MDRIN, ADD, 1'b0);
          push(M_WRITE, ADD, 1'b1);
        end
      end
    end else if (op == 19) begin
      push(M_GRA | M_ROUT | M_CONIN, ADD, 1'b0);
      push(M_PCOUT | M_YIN, ADD, 1'b0);
      push(M_COUT | M_ZIN, ADD, 1'b0);
      push(M_ZLOW | (con ? M_PCIN : 20'h0), ADD, 1'b0);
    end else if (op == 20) begin
      push(M_PCOUT | M_GRB | M_RIN, ADD, 1'b0);
      push(M_GRA | M_ROUT | M_PCIN, ADD, 1'b0);
    end else if (op == 21) begin
      push(M_GRA | M_ROUT | M_PCIN, ADD, 1'b0);
    end
  endfunction

  // Walks one instruction from T0. rnd randomises mem_ack/stop; otherwise mem_ack
  // is held low for dn cycles in step dstep. stop is held from stop_step on (if >=0).
  task automatic run_instr(input string name, input logic [31:0] ir, input logic con,
                           input bit rnd, input int dstep, input int dn,
                           input int stop_step, input int nsteps);
    int n, cyc;
    bit leave, last;
    logic [25:0] obs, exp;
    build_seq(ir[31:27], con);
    n = (nsteps == 0) ? seq.size() : nsteps;
    for (int i = 0; i < n; i++) begin
      cyc = 0;
      do begin
        @(negedge clock);
        obs = observe();
        exp = {seq[i].mask, seq[i].alu, 1'b1};
        tests++;
        if (obs !== exp) begin
          fails++;
          $display("FAIL %s step %0d cyc %0d: got %h want %h", name, i, cyc, obs, exp);
        end
        // IR changes only once T0 is reached, so the previous decision is unaffected
        if (i == 0 && cyc == 0) begin IR = ir; CON_FF = con; end
        last = (i == seq.size() - 1);
        if (seq[i].wt) begin
          if (rnd) mem_ack = (cyc >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
          else     mem_ack = (i == dstep && cyc < dn) ? 1'b0 : 1'b1;
        end else begin
          mem_ack = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (stop_step >= 0) stop = (i >= stop_step);
        else                stop = (rnd && !last) ? 1'($urandom_range(0, 1)) : 1'b0;
        cyc++;
        leave = !seq[i].wt || mem_ack;
        if (!leave && cyc >= 16) begin
          tests++; fails++;
          $display("FAIL %s wait-bound step %0d: got stuck want exit", name, i);
        end
      end while (!leave && cyc < 16);
    end
  endtask

  task automatic expect_idle(input string name, input int n);
    logic [25:0] obs;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      obs = observe();
      tests++;
      if (obs !== 26'h0) begin
        fails++;
        $display("FAIL %s cyc %0d: got %h want 0", name, i, obs);
      end
      mem_ack = 1'($urandom_range(0, 1));
      stop    = 1'($urandom_range(0, 1));
    end
    mem_ack = 1'b1; stop = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ack = 1'b1; stop = 1'b0;
    expect_idle("reset_hold", 3);
    reset = 1'b0;
  endtask

  task automatic test_add();
    run_instr("add", 32'h18918000, 1'b0, 1'b0, -1, 0, -1, 0);
  endtask

  task automatic test_ld_delay();
    run_instr("ld_delay", 32'h02100010, 1'b0, 1'b0, 6, 3, -1, 0);
  endtask

  task automatic test_jal();
    run_instr("jal", 32'hA2800000, 1'b0, 1'b0, -1, 0, -1, 0);
    run_instr("after_jal", 32'h18918000, 1'b0, 1'b0, -1, 0, -1, 0);
  endtask

  task automatic test_br();
    run_instr("br_con0", 32'h98000000, 1'b0, 1'b0, -1, 0, -1, 0);
    run_instr("br_con1", 32'h98000000, 1'b1, 1'b0, -1, 0, -1, 0);
  endtask

  task automatic test_random();
    logic [31:0] ir;
    for (int k = 0; k < 40; k++) begin
      ir = $urandom;
      if (ir[31:27] == 5'd27) ir[31:27] = 5'd26;
      run_instr("random", ir, 1'($urandom_range(0, 1)), 1'b1, -1, 0, -1, 0);
    end
  endtask

  task automatic test_stop_halt();
    logic [25:0] obs;
    run_instr("add_stop", 32'h18918000, 1'b0, 1'b0, -1, 0, 4, 0);
    expect_idle("halt_after_stop", 4);
    // reset pulse between edges must act without a clock edge
    @(negedge clock);
    reset = 1'b1;
    #1;
    obs = observe();
    tests++;
    if (obs !== 26'h0) begin
      fails++;
      $display("FAIL halt_async_reset: got %h want 0", obs);
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_halt_instr();
    run_instr("halt_instr", 32'hD8000000, 1'b0, 1'b0, -1, 0, -1, 0);
    expect_idle("halt_state", 4);
    test_reset();
  endtask

  task automatic test_async_mid();
    logic [25:0] obs;
    run_instr("add_abort", 32'h18918000, 1'b0, 1'b0, -1, 0, -1, 5);
    #1 reset = 1'b1;
    #1;
    obs = observe();
    tests++;
    if (obs !== 26'h0) begin
      fails++;
      $display("FAIL mid_async_reset: got %h want 0", obs);
    end
    @(negedge clock);
    reset = 1'b0;
    run_instr("after_abort", 32'h18918000, 1'b0, 1'b0, -1, 0, -1, 0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_ld_delay();
    test_jal();
    test_br();
    test_random();
    test_stop_halt();
    test_halt_instr();
    test_async_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
